aes_comp_encipher_block: RTL and testbench
==========================================

AES_COMP_ENCIPHER_BLOCK -- requirements
Module: aes_comp_encipher_block

Interface
REQ-001 SHALL have ports:
- clk  in  1  rising-edge clock, the single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- next  in  1  start-encryption pulse; sampled only in IDLE.
- keylen  in  1  key length: 0 = AES-128, 1 = AES-256; sampled with next.
- round  out  4  current round index, used to select the round key from the external key memory.
- round_key  in  128  round key for index round; combinationally valid in the same cycle.
- block  in  128  plaintext; sampled in the INIT cycle.
- new_block  out  128  cipher state as {w0, w1, w2, w3}; valid ciphertext while ready=1 after completion.
- ready  out  1  high when idle or done.

REQ-002 Reset and clocking SHALL be exactly: one clock; reset is synchronous and active-low, clk and reset_n.

Function
REQ-003 The state SHALL be held as four 32-bit word registers w0..w3, each with its own write enable.
REQ-004 The FSM SHALL use states IDLE, INIT, SBOX, MAIN, with no other reachable states.
- An illegal encoding SHALL go to IDLE.
REQ-005 IDLE: when next=1, the block SHALL:
- latch keylen;
- clear the round counter to 0;
- drive ready low on the next edge;
- go to INIT.
REQ-006 INIT:
- new state = block XOR round_key, with round=0;
- increment the round counter;
- clear the sword counter;
- go to SBOX.
REQ-007 SBOX (word-serial):
- substitute word w[sword] through aes_comp_sbox4 and write back only that word;
- increment sword;
- after sword=3, go to MAIN.
REQ-008 MAIN when round < Nr (Nr = 10 or 14 from the latched keylen):
- new state = AddRoundKey(MixColumns(ShiftRows(state)), round_key);
- increment the round counter;
- go to SBOX.
REQ-009 MAIN when round == Nr:
- new state = AddRoundKey(ShiftRows(state), round_key);
- set ready=1;
- go to IDLE.
REQ-010 ShiftRows SHALL rotate row r left by r bytes.
- Byte 0 of each word is bits [31:24].
REQ-011 MixColumns SHALL use the FIPS-197 matrix [2 3 1 1] and GF(2^8) doubling with reduction polynomial 0x1b; all arithmetic is modulo 2^8.
REQ-012 Latency from the next-sampling edge to ready=1, word-serial build: 52 cycles (AES-128) and 72 cycles (AES-256).
REQ-013 next asserted while not in IDLE SHALL be ignored, with no restart and no state corruption.
- A change of keylen mid-operation SHALL have no effect.
REQ-014 new_block SHALL hold its value in IDLE until the next INIT write.
- next in the same cycle that ready rises SHALL be accepted on the following IDLE cycle.
REQ-015 round SHALL equal the round-counter register at all times.
- round never exceeds Nr.

Reset
REQ-016 When reset_n=0 at a rising edge, the block SHALL set:
- w0..w3 = 0, so new_block = 0;
- round counter = 0 and sword counter = 0;
- latched keylen = 0;
- ready = 1;
- FSM = IDLE.
REQ-017 A reset mid-operation SHALL abort the operation with no residual effect.
- The first next after reset SHALL behave as a fresh start.

Configuration
REQ-018 With macro AES_COMP_ENC_SBOX_PAR_EN defined, the block SHALL use four aes_comp_sbox4 instances.
- SBOX lasts one cycle and substitutes all 128 bits.
- The sword counter SHALL be absent.
- Latency becomes 22 cycles (AES-128) and 30 cycles (AES-256).
REQ-019 Without the macro, the block SHALL use one aes_comp_sbox4 instance with four SBOX cycles per round.
- Outputs are bit-identical in both builds; only latency differs.

Structure
REQ-020 Shared package aes_comp_pkg SHALL hold:
- AES128_ROUNDS (4'ha) and AES256_ROUNDS (4'he);
- key-length codes;
- the FSM state encoding;
- the update-type encoding;
- the GF(2^8) gm2/gm3 helper functions.
REQ-021 aes_comp_sbox4 SHALL be the only sub-module: a combinational 32-bit forward S-box, four parallel bytes.
- All round logic lives in this block.

Verification
REQ-022 The bench SHALL drive round_key from an FIPS-197 key-expansion model indexed by round, and SHALL cover:
- AES-128, key 000102…0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; ready rises exactly 52 cycles after next (22 cycles with PAR_EN).
- AES-256, key 000102…1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089 at 72 cycles (30 with PAR_EN); round sequence 0..14 monotonic.
- next re-pulsed at cycle 10, and keylen toggled mid-run -> same AES-128 ciphertext and same latency.
- reset_n low at cycle 20 -> next edge gives ready=1, new_block=0, round=0; a subsequent run yields the correct ciphertext.
- Back-to-back: next held high continuously across two runs -> two correct ciphertexts; new_block stable in IDLE between runs.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_comp_pkg.sv
// rtl/aes_comp_pkg.sv - shared constants, encodings and GF(2^8) helpers for the AES encipher block
//
// Contents:
//   AES128_ROUNDS / AES256_ROUNDS : final round index Nr for each key length
//   KEYLEN_128 / KEYLEN_256       : codes carried on the keylen input
//   state_t                       : encipher FSM state encoding
//   update_t                      : which datapath update is applied to w0..w3
//   gm2 / gm3                     : GF(2^8) multiply by 2 and 3, polynomial 0x11b
package aes_comp_pkg;

    localparam logic [3:0] AES128_ROUNDS = 4'ha;
    localparam logic [3:0] AES256_ROUNDS = 4'he;

    localparam logic KEYLEN_128 = 1'b0;
    localparam logic KEYLEN_256 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        UPD_NONE  = 3'd0,
        UPD_INIT  = 3'd1,
        UPD_SBOX  = 3'd2,
        UPD_MAIN  = 3'd3,
        UPD_FINAL = 3'd4
    } update_t;

    // Doubling in GF(2^8): shift left, fold the carried-out bit back with 0x1b.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_comp_sbox4.sv
// rtl/aes_comp_sbox4.sv - combinational forward AES S-box on four bytes in parallel
//
// Ports:
//   sboxw     in  32  word to substitute, byte 0 in bits [31:24]
//   new_sboxw out 32  substituted word, same byte order
module aes_comp_sbox4 (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign new_sboxw = {SBOX[sboxw[31:24]], SBOX[sboxw[23:16]],
                        SBOX[sboxw[15:8]],  SBOX[sboxw[7:0]]};

endmodule

// File: rtl/aes_comp_encipher_block.sv
// rtl/aes_comp_encipher_block.sv - iterative AES-128/256 encipher datapath and control
//
// Ports:
//   clk        in   1    rising-edge clock
//   reset_n    in   1    synchronous active-low reset
//   next       in   1    start pulse, only looked at in IDLE
//   keylen     in   1    0 = AES-128, 1 = AES-256, captured together with next
//   round      out  4    round index used to address the external key memory
//   round_key  in   128  key for the current round, valid in the same cycle
//   block      in   128  plaintext, taken in the INIT cycle
//   new_block  out  128  cipher state {w0, w1, w2, w3}
//   ready      out  1    high while idle / done
//
// Build option: AES_COMP_ENC_SBOX_PAR_EN selects four S-box instances and a
// single-cycle SBOX step; otherwise one shared S-box walks the four words.
module aes_comp_encipher_block
    import aes_comp_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [31:0] c0, c1, c2, c3;
        c0 = s[127:96];
        c1 = s[95:64];
        c2 = s[63:32];
        c3 = s[31:0];
        // Word c, byte r takes byte r of word (c + r) mod 4.
        return {c0[31:24], c1[23:16], c2[15:8], c3[7:0],
                c1[31:24], c2[23:16], c3[15:8], c0[7:0],
                c2[31:24], c3[23:16], c0[15:8], c1[7:0],
                c3[31:24], c0[23:16], c1[15:8], c2[7:0]};
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
                b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]),
                mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  round_q;
    logic        keylen_q;
    logic        ready_q;
    logic [31:0] w0_q, w1_q, w2_q, w3_q;

    update_t     upd;
    logic        round_clr, round_inc;
    logic        keylen_we;
    logic        ready_set, ready_clr;
    logic [3:0]  num_rounds;
    logic        last_round;

    logic [127:0] state_cat;
    logic [127:0] sr_state;
    logic [127:0] mc_state;
    logic [127:0] w_new;
    logic [3:0]   w_we;   // [3] -> w0 ... [0] -> w3

`ifndef AES_COMP_ENC_SBOX_PAR_EN
    logic [1:0]  sword_q;
    logic        sword_clr, sword_inc;
    logic [31:0] sbox_in, sbox_out;
`else
    logic [127:0] sub_all;
`endif

    assign num_rounds = (keylen_q == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;
    assign last_round = (round_q == num_rounds);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = next ? ST_INIT : ST_IDLE;
            ST_INIT: state_d = ST_SBOX;
`ifdef AES_COMP_ENC_SBOX_PAR_EN
            ST_SBOX: state_d = ST_MAIN;
`else
            ST_SBOX: state_d = (sword_q == 2'd3) ? ST_MAIN : ST_SBOX;
`endif
            ST_MAIN: state_d = last_round ? ST_IDLE : ST_SBOX;
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        upd       = UPD_NONE;
        round_clr = 1'b0;
        round_inc = 1'b0;
        keylen_we = 1'b0;
        ready_set = 1'b0;
        ready_clr = 1'b0;
`ifndef AES_COMP_ENC_SBOX_PAR_EN
        sword_clr = 1'b0;
        sword_inc = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (next) begin
                    keylen_we = 1'b1;
                    round_clr = 1'b1;
                    ready_clr = 1'b1;
                end
            end
            ST_INIT: begin
                upd       = UPD_INIT;
                round_inc = 1'b1;
`ifndef AES_COMP_ENC_SBOX_PAR_EN
                sword_clr = 1'b1;
`endif
            end
            ST_SBOX: begin
                upd = UPD_SBOX;
`ifndef AES_COMP_ENC_SBOX_PAR_EN
                sword_inc = 1'b1;
`endif
            end
            ST_MAIN: begin
                if (last_round) begin
                    upd       = UPD_FINAL;
                    ready_set = 1'b1;
                end else begin
                    upd       = UPD_MAIN;
                    round_inc = 1'b1;
                end
            end
            default: upd = UPD_NONE;
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            round_q  <= 4'd0;
            keylen_q <= KEYLEN_128;
            ready_q  <= 1'b1;
        end else begin
            if (round_clr) begin
                round_q <= 4'd0;
            end else if (round_inc) begin
                round_q <= round_q + 4'd1;
            end
            if (keylen_we) begin
                keylen_q <= keylen;
            end
            if (ready_clr) begin
                ready_q <= 1'b0;
            end else if (ready_set) begin
                ready_q <= 1'b1;
            end
        end
    end

`ifndef AES_COMP_ENC_SBOX_PAR_EN
    // Wraps from 3 to 0 on the last SBOX cycle, so it is already clear for the next round.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sword_q <= 2'd0;
        end else if (sword_clr) begin
            sword_q <= 2'd0;
        end else if (sword_inc) begin
            sword_q <= sword_q + 2'd1;
        end
    end
`endif

    // ---------------- datapath ----------------
    assign state_cat = {w0_q, w1_q, w2_q, w3_q};
    assign sr_state  = shift_rows(state_cat);
    assign mc_state  = mix_columns(sr_state);

`ifdef AES_COMP_ENC_SBOX_PAR_EN
    aes_comp_sbox4 u_sbox0 (.sboxw(w0_q), .new_sboxw(sub_all[127:96]));
    aes_comp_sbox4 u_sbox1 (.sboxw(w1_q), .new_sboxw(sub_all[95:64]));
    aes_comp_sbox4 u_sbox2 (.sboxw(w2_q), .new_sboxw(sub_all[63:32]));
    aes_comp_sbox4 u_sbox3 (.sboxw(w3_q), .new_sboxw(sub_all[31:0]));
`else
    always_comb begin
        sbox_in = w0_q;
        case (sword_q)
            2'd0:    sbox_in = w0_q;
            2'd1:    sbox_in = w1_q;
            2'd2:    sbox_in = w2_q;
            default: sbox_in = w3_q;
        endcase
    end

    aes_comp_sbox4 u_sbox (.sboxw(sbox_in), .new_sboxw(sbox_out));
`endif

    always_comb begin
        w_new = state_cat;
        w_we  = 4'b0000;
        case (upd)
            UPD_INIT: begin
                w_new = block ^ round_key;
                w_we  = 4'b1111;
            end
            UPD_SBOX: begin
`ifdef AES_COMP_ENC_SBOX_PAR_EN
                w_new = sub_all;
                w_we  = 4'b1111;
`else
                // Only the word selected by sword is enabled.
                w_new = {4{sbox_out}};
                w_we  = 4'b1000 >> sword_q;
`endif
            end
            UPD_MAIN: begin
                w_new = mc_state ^ round_key;
                w_we  = 4'b1111;
            end
            UPD_FINAL: begin
                w_new = sr_state ^ round_key;
                w_we  = 4'b1111;
            end
            default: begin
                w_new = state_cat;
                w_we  = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w0_q <= 32'd0;
            w1_q <= 32'd0;
            w2_q <= 32'd0;
            w3_q <= 32'd0;
        end else begin
            if (w_we[3]) w0_q <= w_new[127:96];
            if (w_we[2]) w1_q <= w_new[95:64];
            if (w_we[1]) w2_q <= w_new[63:32];
            if (w_we[0]) w3_q <= w_new[31:0];
        end
    end

    assign round     = round_q;
    assign new_block = state_cat;
    assign ready     = ready_q;

endmodule

// File: tb/tb_aes_comp_encipher_block.sv
// tb/tb_aes_comp_encipher_block.sv - self-checking bench for aes_comp_encipher_block
module tb_aes_comp_encipher_block;

`ifdef AES_COMP_ENC_SBOX_PAR_EN
    localparam int LAT128 = 22;
    localparam int LAT256 = 30;
`else
    localparam int LAT128 = 52;
    localparam int LAT256 = 72;
`endif

    logic         clk;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    aes_comp_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         kl;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           lat;
        int           nr;
    } vec_t;

    vec_t         vecs [3];
    logic [127:0] rk [16];
    logic [7:0]   sbox_m [256];
    logic [127:0] exp_q [$];
    int           total;
    int           bad;
    int           max_round;
    bit           mono_ok;

    assign round_key = rk[round];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box derived from the multiplicative inverse and the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        logic [7:0] yb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yb = 8'(y);
                if (xb != 8'h00 && gmul(xb, yb) == 8'h01) inv = yb;
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand(input logic kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        int nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else         rk[r] = 128'h0;
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic start_run(input logic kl, input logic [127:0] pt, input logic [127:0] ct);
        keylen = kl;
        block  = pt;
        exp_q.push_back(ct);
        next   = 1'b1;
    endtask

    // Counts edges from the edge that samples next (count 1) until ready is seen high.
    task automatic wait_ready(input bit drop_next, input bit disturb, output int cyc);
        int prev;
        prev      = 0;
        mono_ok   = 1'b1;
        max_round = 0;
        cyc       = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (drop_next) next = 1'b0;
            if (disturb && cyc == 10) begin
                next   = 1'b1;
                keylen = ~keylen;
            end
            if (int'(round) < prev) mono_ok = 1'b0;
            prev = int'(round);
            if (int'(round) > max_round) max_round = int'(round);
            if (ready) break;
        end
    endtask

    task automatic finish_run(input string name, input int cyc, input int lat);
        logic [127:0] e;
        check({name, " latency"}, 128'(cyc), 128'(lat));
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s scoreboard: got output with no expected entry", name);
        end else begin
            total--;
            e = exp_q.pop_front();
            check({name, " ciphertext"}, new_block, e);
        end
    endtask

    initial begin
        int cyc;
        total = 0;
        bad   = 0;
        build_sbox();
        for (int r = 0; r < 16; r++) rk[r] = 128'h0;

        vecs[0] = '{1'b0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h00112233445566778899aabbccddeeff,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, LAT128, 10};
        vecs[1] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h00112233445566778899aabbccddeeff,
                    128'h8ea2b7ca516745bfeafc49904b496089, LAT256, 14};
        vecs[2] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3243f6a8885a308d313198a2e0370734,
                    128'h3925841d02dc09fbdc118597196a0b32, LAT128, 10};

        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = 128'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 128'(ready), 128'd1);
        check("reset new_block", new_block, 128'h0);
        check("reset round", 128'(round), 128'd0);
        reset_n = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 3; i++) begin
            expand(vecs[i].kl, vecs[i].key);
            @(posedge clk);
            #1;
            start_run(vecs[i].kl, vecs[i].pt, vecs[i].ct);
            wait_ready(1'b1, 1'b0, cyc);
            finish_run($sformatf("vec%0d", i), cyc, vecs[i].lat);
            check($sformatf("vec%0d final round", i), 128'(max_round), 128'(vecs[i].nr));
            check($sformatf("vec%0d round monotonic", i), 128'(mono_ok), 128'd1);
        end

        // next re-pulsed and keylen flipped mid-run.
        expand(vecs[0].kl, vecs[0].key);
        @(posedge clk);
        #1;
        start_run(1'b0, vecs[0].pt, vecs[0].ct);
        wait_ready(1'b1, 1'b1, cyc);
        finish_run("disturb", cyc, LAT128);
        keylen = 1'b0;

        // Reset in the middle of a run, then a fresh run.
        @(posedge clk);
        #1;
        keylen = 1'b0;
        block  = vecs[0].pt;
        next   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            next = 1'b0;
        end
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset ready", 128'(ready), 128'd1);
        check("midreset new_block", new_block, 128'h0);
        check("midreset round", 128'(round), 128'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_run(1'b0, vecs[0].pt, vecs[0].ct);
        wait_ready(1'b1, 1'b0, cyc);
        finish_run("after reset", cyc, LAT128);

        // Back-to-back with next held high.
        expand(vecs[2].kl, vecs[2].key);
        @(posedge clk);
        #1;
        start_run(1'b0, vecs[2].pt, vecs[2].ct);
        exp_q.push_back(vecs[2].ct);
        wait_ready(1'b0, 1'b0, cyc);
        finish_run("b2b run1", cyc, LAT128);
        @(posedge clk);
        #1;
        check("b2b restart accepted", 128'(ready), 128'd0);
        check("b2b new_block hold", new_block, vecs[2].ct);
        wait_ready(1'b0, 1'b0, cyc);
        next = 1'b0;
        finish_run("b2b run2", cyc + 1, LAT128);
        repeat (5) @(posedge clk);
        #1;
        check("idle ready", 128'(ready), 128'd1);
        check("idle new_block hold", new_block, vecs[2].ct);
        check("scoreboard drained", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
